// File: rtl/gate_exhaustive_checker.sv
// Exhaustive stimulus/response checker for small combinational gates: walks every
// input vector, compares against a reference function. Optional GATE_CHECKER_TRACE_EN adds a mismatch trace port.
module gate_exhaustive_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    output logic [N_IN-1:0]  stim,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [N_IN-1:0]  first_err_vec
`ifdef GATE_CHECKER_TRACE_EN
    ,
    output logic             err_strobe,
    output logic [N_IN-1:0]  err_vec,
    output logic             err_exp
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             exp_y;
    logic             mismatch;
    logic             last_vec;
    logic [ERR_W-1:0] err_nxt;

    function automatic logic ref_fn(input logic [2:0] f, input logic [N_IN-1:0] v);
        case (f)
            3'd0:    return ~&v;
            3'd1:    return &v;
            3'd2:    return |v;
            3'd3:    return ~|v;
            3'd4:    return ^v;
            3'd5:    return ~^v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    // Reserved ops force a mismatch; the case-inequality also flags X/Z on dut_y.
    always_comb begin
        exp_y    = ref_fn(op_q, stim);
        mismatch = (op_q > 3'd5) || (dut_y !== exp_y);
        last_vec = &stim;
        err_nxt  = mismatch ? sat_inc(err_count) : err_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == '0) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = last_vec ? S_DONE : S_SETTLE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // pass is resolved on the final CHECK so it is already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q            <= '0;
            cnt             <= '0;
            stim            <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q            <= op;
                        stim            <= '0;
                        cnt             <= CNT_LOAD;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                S_CHECK: begin
                    err_count <= err_nxt;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= stim;
                    end
                    if (last_vec) begin
                        pass <= (err_nxt == '0);
                    end else begin
                        stim <= stim + N_IN'(1);
                        cnt  <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_CHECKER_TRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_strobe <= 1'b0;
            err_vec    <= '0;
            err_exp    <= 1'b0;
        end else begin
            err_strobe <= (state == S_CHECK) && mismatch;
            if ((state == S_CHECK) && mismatch) begin
                err_vec <= stim;
                err_exp <= exp_y;
            end
        end
    end
`endif

endmodule
